// File: rtl/switch_pkg.sv
// Shared constants and helpers for the N x N virtual-output-queued switch.
package switch_pkg;

  localparam int N_PORTS_DEF    = 4;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int STAT_W         = 16;

  function automatic int dest_width(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// Virtual output queue: a written entry becomes visible to the reader one cycle
// after the write, so the full path from acceptance to out_valid is two edges.
module switch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       wr_vis_r;
  logic [AW:0]       rd_ptr_r;

  // Full is judged on the true write pointer, empty on the delayed one.
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_vis_r == rd_ptr_r);
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      wr_vis_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      wr_vis_r <= wr_ptr_r;
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array; contents are don't-care until the pointers expose them
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/switch_nxn.sv
// N x N switch with one queue per (input, output) pair and a round-robin registered
// output stage per port. Optional macro SWITCH_STATS_EN adds per-output handshake counters.
module switch_nxn
  import switch_pkg::*;
#(
  parameter int N_PORTS    = N_PORTS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  input  logic [N_PORTS-1:0]          in_valid,
  output logic [N_PORTS-1:0]          in_ready,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  output logic [N_PORTS-1:0]          out_valid,
  input  logic [N_PORTS-1:0]          out_ready
`ifdef SWITCH_STATS_EN
  ,output logic [N_PORTS*STAT_W-1:0]  stat_cnt
`endif
);

  localparam int DEST_W = dest_width(N_PORTS);

  logic [N_PORTS-1:0] full_row_s  [N_PORTS];
  logic [N_PORTS-1:0] push_row_s  [N_PORTS];
  logic [N_PORTS-1:0] empty_col_s [N_PORTS];
  logic [N_PORTS-1:0] pop_col_s   [N_PORTS];
  logic [DATA_W-1:0]  q_dout_s    [N_PORTS][N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_in
    logic [DEST_W-1:0]  dest_s;
    logic [N_PORTS-1:0] hit_s;

    assign dest_s = in_data[i*DATA_W + DATA_W - DEST_W +: DEST_W];

    // Destination decode; an out-of-range destination hits nothing and is dropped
    always_comb begin
      hit_s = {N_PORTS{1'b0}};
      for (int j = 0; j < N_PORTS; j++) begin
        hit_s[j] = (int'(dest_s) == j);
      end
    end

    assign in_ready[i]   = ~|(hit_s & full_row_s[i]);
    assign push_row_s[i] = hit_s & ~full_row_s[i] & {N_PORTS{in_valid[i]}};

    for (genvar j = 0; j < N_PORTS; j++) begin : g_q
      switch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_row_s[i][j]),
        .pop   (pop_col_s[j][i]),
        .din   (in_data[i*DATA_W +: DATA_W]),
        .dout  (q_dout_s[j][i]),
        .full  (full_row_s[i][j]),
        .empty (empty_col_s[j][i])
      );
    end
  end

  for (genvar j = 0; j < N_PORTS; j++) begin : g_out
    logic [DEST_W-1:0]  last_r;
    logic [DEST_W-1:0]  gnt_s;
    logic               any_s;
    logic               take_s;
    logic               valid_r;
    logic [DATA_W-1:0]  data_r;
    logic [N_PORTS-1:0] req_s;
    logic [N_PORTS-1:0] pop_s;

    assign req_s = ~empty_col_s[j];

    // Round-robin scan from farthest to nearest, so the requester just after last_r wins
    always_comb begin
      int                sum;
      logic [DEST_W-1:0] idx;
      gnt_s = last_r;
      any_s = 1'b0;
      sum   = 0;
      idx   = {DEST_W{1'b0}};
      for (int k = N_PORTS; k >= 1; k--) begin
        sum   = int'(last_r) + k;
        idx   = DEST_W'((sum >= N_PORTS) ? (sum - N_PORTS) : sum);
        gnt_s = req_s[idx] ? idx : gnt_s;
        any_s = any_s | req_s[idx];
      end
    end

    assign take_s = any_s && (!valid_r || out_ready[j]);

    // One-hot pop back to the granted queue
    always_comb begin
      pop_s = {N_PORTS{1'b0}};
      for (int k = 0; k < N_PORTS; k++) begin
        pop_s[k] = take_s && (int'(gnt_s) == k);
      end
    end

    assign pop_col_s[j] = pop_s;

    // Output register: refills when empty or when the sink consumes the held word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_r <= 1'b0;
        data_r  <= {DATA_W{1'b0}};
        last_r  <= DEST_W'(N_PORTS - 1);
      end else if (take_s) begin
        valid_r <= 1'b1;
        data_r  <= q_dout_s[j][gnt_s];
        last_r  <= gnt_s;
      end else if (out_ready[j]) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end

    assign out_valid[j]                  = valid_r;
    assign out_data[j*DATA_W +: DATA_W]  = data_r;

`ifdef SWITCH_STATS_EN
    logic [STAT_W-1:0] cnt_r;

    // Saturating handshake counter
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r <= {STAT_W{1'b0}};
      end else if (valid_r && out_ready[j] && (cnt_r != {STAT_W{1'b1}})) begin
        cnt_r <= cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign stat_cnt[j*STAT_W +: STAT_W] = cnt_r;
`endif
  end

endmodule

// File: doc/switch_nxn.md
SWITCH_NXN -- requirements
Module: switch_nxn

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of input and output ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, word width including the destination field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per virtual output queue (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  N_PORTS*DATA_W  input words, port i in slice [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_valid  input  N_PORTS  per-input word valid.
REQ-008 SHALL have port in_ready  output  N_PORTS  per-input accept.
REQ-009 SHALL have port out_data  output  N_PORTS*DATA_W  output words, same slicing.
REQ-010 SHALL have port out_valid  output  N_PORTS  per-output word valid.
REQ-011 SHALL have port out_ready  input  N_PORTS  per-output sink ready.

Function
REQ-012 Destination SHALL be in_data slice bits [DATA_W-1 -: DEST_W], with DEST_W = $clog2(N_PORTS); word forwarded unmodified.
REQ-013 SHALL hold one FIFO per (input i, output j) pair, N_PORTS*N_PORTS in total, each FIFO_DEPTH deep.
REQ-014 in_ready[i] SHALL be high iff FIFO(i, dest of in_data[i]) is not full, from current occupancy only; no pass-through of a same-cycle read.
REQ-015 Word SHALL be accepted when in_valid[i] and in_ready[i] are high at a rising edge; it is written into FIFO(i, dest).
REQ-016 Destination >= N_PORTS SHALL force in_ready[i] high; the word is discarded.
REQ-017 Each output j SHALL have a registered output stage; it loads when empty or when out_valid[j] and out_ready[j] are both high.
REQ-018 Output j SHALL select among non-empty FIFO(*, j) round-robin: highest priority at input (last_grant+1) mod N_PORTS; last_grant is N_PORTS-1 after reset, so input 0 has first priority.
REQ-019 Latency SHALL be 2 cycles from the acceptance edge to out_valid when the path is idle; sustained throughput 1 word/cycle per output.
REQ-020 Order SHALL be preserved per (input, output) pair; no word lost or duplicated except under REQ-016.
REQ-021 out_valid/out_data SHALL hold stable while out_ready is low.
REQ-022 Different inputs targeting different outputs SHALL proceed concurrently without interference.

Reset
REQ-023 rst low SHALL asynchronously clear all FIFOs, set out_valid=0, out_data=0 and all round-robin pointers to reset state.
REQ-024 After reset, in_ready SHALL reflect empty FIFOs (all high); a reset mid-transfer discards all in-flight words.
REQ-025 Reset deassertion SHALL be sampled synchronously; first acceptance is possible on the first edge after deassertion.

Configuration
REQ-026 With SWITCH_STATS_EN defined, port stat_cnt  output  N_PORTS*16 SHALL exist: per-output 16-bit count of out_valid&out_ready handshakes, saturating at 16'hFFFF, cleared by reset.
REQ-027 Without SWITCH_STATS_EN, the stat_cnt port and its counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package switch_pkg SHALL hold the default parameter constants, a function computing DEST_W, and the counter-width constant STAT_W=16.
REQ-029 The FIFO SHALL be sub-module switch_fifo (parameters DATA_W and DEPTH; ports full, empty, push, pop, din, dout), instantiated N_PORTS^2 times via generate.
REQ-030 Arbiter and output stage SHALL be inline per-output generate logic.

Verification (N_PORTS=4, DATA_W=32, FIFO_DEPTH=4)
REQ-031 Input 0 sends 32'h4000_00AA (dest 1), out_ready all high -> out_valid[1] exactly 2 cycles later with 32'h4000_00AA; other outputs stay idle.
REQ-032 Inputs 0..3 all send to dest 2 every cycle, out_ready[2]=1 -> output 2 grants 0,1,2,3,0,... one word/cycle, per-input order intact.
REQ-033 out_ready[3]=0, input 1 sends 5 words to dest 3 -> 4 accepted; then in_ready[1] goes low while dest 3 is presented until out_ready[3] rises. The output register can hold one more word, so accepted count may be 5: bench SHALL check in_ready falls once FIFO(1,3) is full.
REQ-034 rst pulsed low mid-burst with 3 words queued -> out_valid=0 immediately; no queued word emerges after release.
REQ-035 out_ready toggles 1,0,1,0 under continuous traffic -> out_data stable during low cycles; no loss or duplication (scoreboard).
REQ-036 With SWITCH_STATS_EN, 70000 words to output 0 -> stat_cnt[15:0]=16'hFFFF.
